// File: rtl/pipe_arbiter_pkg.sv
// Shared types and helpers for pipe_arbiter: result tags, lock states,
// the round-robin pick function and the id-width helper.
package pipe_arbiter_pkg;

  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_e;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid_vec scanning upward from ptr and wrapping at num_req.
  // The result is meaningless when valid_vec has no bit set below num_req.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid_vec,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  num_req = MAX_REQ
  );
    logic [MAX_ID_W-1:0] pick;
    logic [MAX_ID_W:0]   idx;
    logic                found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (MAX_ID_W+1)'(k);
      if (idx >= (MAX_ID_W+1)'(num_req)) idx = idx - (MAX_ID_W+1)'(num_req);
      if (!found && (k < num_req) && valid_vec[idx[MAX_ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[MAX_ID_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pipe_arbiter_if.sv
// Requester, datapath and response signals of pipe_arbiter.
// slave is the arbiter side, master the requester/datapath side.
interface pipe_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [DATA_WIDTH-1:0]         pipe_din;
  logic                          pipe_din_valid;
  logic [DATA_WIDTH-1:0]         pipe_dout;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_data, req_last, pipe_dout,
    output req_ready, pipe_din, pipe_din_valid, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_data, req_last, pipe_dout,
    input  req_ready, pipe_din, pipe_din_valid, rsp_valid, rsp_data
  );

endinterface

// File: rtl/pipe_arbiter_rr_arbiter.sv
// Round-robin grant over the masked request vector plus the priority pointer.
// The pointer moves past the winner only when advance is asserted.
module rr_arbiter
  import pipe_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        mask,
  input  logic                      advance,
  output logic [NUM_REQ-1:0]        grant,
  output logic [id_w(NUM_REQ)-1:0]  grant_id
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  eligible;
  logic [MAX_REQ-1:0]  eligible_ext;
  logic [MAX_ID_W-1:0] pick;

  assign eligible = req_valid & mask;

  always_comb begin
    eligible_ext                = '0;
    eligible_ext[NUM_REQ-1:0]   = eligible;
    pick                        = rr_pick(eligible_ext, MAX_ID_W'(ptr), NUM_REQ);
    grant_id                    = ID_W'(pick);
    grant                       = '0;
    if (|eligible) grant = NUM_REQ'(1) << grant_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && (|grant)) begin
      ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin front end sharing one fixed-latency datapath between requesters.
// Define PIPE_ARBITER_LOCK_EN to hold the grant on one requester until req_last.
module pipe_arbiter
  import pipe_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 8
) (
  input logic           clk,
  input logic           rst,
  pipe_arbiter_if.slave bus
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] mask;
  logic [ID_W-1:0]    grant_id;
  logic               advance;
  logic               handshake;
  tag_t               tag_head;
  tag_t               tag_out;

  assign handshake     = |grant;
  assign bus.req_ready = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .mask      (mask),
    .advance   (advance),
    .grant     (grant),
    .grant_id  (grant_id)
  );

`ifdef PIPE_ARBITER_LOCK_EN
  lock_state_e     state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOCK_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // A locked burst only lets its owner through and freezes the pointer until
  // the owner's closing beat, which then moves the pointer past the owner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mask    = '1;
    advance = handshake;
    case (state_q)
      LOCK_IDLE: begin
        if (handshake && !bus.req_last[grant_id]) begin
          state_d = LOCK_HELD;
          owner_d = grant_id;
        end
      end
      LOCK_HELD: begin
        mask    = NUM_REQ'(1) << owner_q;
        advance = handshake && bus.req_last[owner_q];
        if (advance) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end
`else
  assign mask    = '1;
  assign advance = handshake;
`endif

  // tag_head travels alongside pipe_din, so it is stage 0 of the tag line.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pipe_din       <= '0;
      bus.pipe_din_valid <= 1'b0;
      tag_head           <= '0;
    end else begin
      bus.pipe_din_valid <= handshake;
      tag_head           <= '{valid: handshake, id: MAX_ID_W'(grant_id)};
      if (handshake) bus.pipe_din <= bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  if (LATENCY == 0) begin : g_no_delay
    assign tag_out = tag_head;
  end else begin : g_delay
    tag_t stage [LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
        stage[0] <= tag_head;
        for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
    end

    assign tag_out = stage[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else if (tag_out.valid) begin
      bus.rsp_valid <= NUM_REQ'(1) << tag_out.id;
      bus.rsp_data  <= bus.pipe_dout;
    end else begin
      bus.rsp_valid <= '0;
    end
  end

endmodule
